ray_march_ctrl: RTL and testbench

RAY_MARCH_CTRL -- requirements
Module: ray_march_ctrl

---
 rtl/ray_march_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_ray_march_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ray_march_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ray_march_ctrl
// Purpose  : Sphere-tracing controller. Accepts one ray at a time, drives
//            sample positions origin + t*dir to an external signed-distance
//            evaluator and advances t by the returned distance until a hit,
//            a miss (t beyond MAX_DIST) or the step budget runs out.
// Ports    : clk, rst_n         - clock, asynchronous active-low reset
//            ray_valid/ray_ready, ray_origin, ray_dir - ray input handshake
//            query_pos, query_dist - SDF evaluator interface
//            res_valid/res_ready, res_hit, res_t - result handshake
//            res_steps          - SDF evaluations used (stats build only)
// Config   : define RAY_MARCH_STATS_EN to add the res_steps output.
// Vectors  : vec3 packing is {z, y, x}, x in [31:0]; all fp values are
//            signed Q8.24.
// Revision : 1.0 - initial release
// ============================================================================
module ray_march_ctrl #(
  parameter int          SDF_LATENCY = 2,
  parameter int          MAX_STEPS   = 64,
  parameter logic [31:0] HIT_EPS     = 32'h00004189,
  parameter logic [31:0] MAX_DIST    = 32'h0A000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ray_valid,
  output logic        ray_ready,
  input  logic [95:0] ray_origin,
  input  logic [95:0] ray_dir,
  output logic [95:0] query_pos,
  input  logic [31:0] query_dist,
  output logic        res_valid,
  input  logic        res_ready,
  output logic        res_hit,
  output logic [31:0] res_t
`ifdef RAY_MARCH_STATS_EN
  ,
  output logic [7:0]  res_steps
`endif
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_EVAL  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam int               WAIT_W      = (SDF_LATENCY > 1) ? $clog2(SDF_LATENCY) : 1;
  localparam logic [WAIT_W-1:0] C_WAIT_LAST = WAIT_W'(SDF_LATENCY - 1);
  localparam logic [7:0]       C_MAX_STEPS = 8'(MAX_STEPS);

  logic [2:0]        state_q, state_d;
  logic [95:0]       origin_q, origin_d;
  logic [95:0]       dir_q, dir_d;
  logic [31:0]       t_q, t_d;
  logic [7:0]        step_q, step_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [95:0]       query_pos_q, query_pos_d;
  logic              ray_ready_q, ray_ready_d;
  logic              res_valid_q, res_valid_d;
  logic              res_hit_q, res_hit_d;
  logic [31:0]       res_t_q, res_t_d;
`ifdef RAY_MARCH_STATS_EN
  logic [7:0]        res_steps_q, res_steps_d;
`endif

  // Sample position for the current t, one multiply-add per axis.
  logic [95:0] w_pos;
  for (genvar i = 0; i < 3; i++) begin : g_axis
    logic signed [63:0] w_t_ext;
    logic signed [63:0] w_dir_ext;
    logic signed [63:0] w_prod;
    logic               w_unused_prod;
    assign w_t_ext   = {{32{t_q[31]}}, t_q};
    assign w_dir_ext = {{32{dir_q[32*i+31]}}, dir_q[32*i +: 32]};
    assign w_prod    = w_t_ext * w_dir_ext;
    // Q8.24 * Q8.24 = Q16.48; keep the Q8.24 window, drop the rest.
    assign w_pos[32*i +: 32] = origin_q[32*i +: 32] + w_prod[55:24];
    assign w_unused_prod     = ^{w_prod[63:56], w_prod[23:0]};
  end

  logic [31:0] w_t_plus_d;
  logic [7:0]  w_step_inc;
  logic        w_hit;
  logic        w_far;
  logic        w_last;

  assign w_t_plus_d = t_q + query_dist;
  assign w_step_inc = step_q + 8'd1;
  assign w_hit      = $signed(query_dist) < $signed(HIT_EPS);
  assign w_far      = $signed(w_t_plus_d) > $signed(MAX_DIST);
  assign w_last     = (w_step_inc == C_MAX_STEPS);

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      origin_q    <= '0;
      dir_q       <= '0;
      t_q         <= '0;
      step_q      <= '0;
      wait_q      <= '0;
      query_pos_q <= '0;
      ray_ready_q <= 1'b0;
      res_valid_q <= 1'b0;
      res_hit_q   <= 1'b0;
      res_t_q     <= '0;
`ifdef RAY_MARCH_STATS_EN
      res_steps_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      origin_q    <= origin_d;
      dir_q       <= dir_d;
      t_q         <= t_d;
      step_q      <= step_d;
      wait_q      <= wait_d;
      query_pos_q <= query_pos_d;
      ray_ready_q <= ray_ready_d;
      res_valid_q <= res_valid_d;
      res_hit_q   <= res_hit_d;
      res_t_q     <= res_t_d;
`ifdef RAY_MARCH_STATS_EN
      res_steps_q <= res_steps_d;
`endif
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (ray_valid && ray_ready_q) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (wait_q == C_WAIT_LAST) state_d = S_EVAL;
      S_EVAL:  state_d = (w_hit || w_far || w_last) ? S_DONE : S_ISSUE;
      S_DONE:  if (res_valid_q && res_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath logic.
  always_comb begin
    origin_d    = origin_q;
    dir_d       = dir_q;
    t_d         = t_q;
    step_d      = step_q;
    wait_d      = wait_q;
    query_pos_d = query_pos_q;
    res_hit_d   = res_hit_q;
    res_t_d     = res_t_q;
`ifdef RAY_MARCH_STATS_EN
    res_steps_d = res_steps_q;
`endif
    // Registered from the next state so ray_ready stays low until the first
    // clock after reset release, then mirrors "in IDLE".
    ray_ready_d = (state_d == S_IDLE);
    // Low on the DONE entry cycle, high while DONE persists, dropped on the
    // handshake edge.
    res_valid_d = (state_q == S_DONE) && (state_d == S_DONE);

    case (state_q)
      S_IDLE: begin
        if (ray_valid && ray_ready_q) begin
          origin_d = ray_origin;
          dir_d    = ray_dir;
          t_d      = '0;
          step_d   = '0;
        end
      end
      S_ISSUE: begin
        query_pos_d = w_pos;
        wait_d      = '0;
      end
      S_WAIT: begin
        wait_d = wait_q + 1'b1;
      end
      S_EVAL: begin
        step_d = w_step_inc;
`ifdef RAY_MARCH_STATS_EN
        res_steps_d = w_step_inc;
`endif
        if (w_hit) begin
          res_hit_d = 1'b1;
          res_t_d   = t_q;
        end else if (w_far) begin
          res_hit_d = 1'b0;
          t_d       = w_t_plus_d;
          res_t_d   = w_t_plus_d;
        end else if (w_last) begin
          res_hit_d = 1'b0;
          res_t_d   = t_q;
        end else begin
          t_d = w_t_plus_d;
        end
      end
      default: ;
    endcase
  end

  assign ray_ready = ray_ready_q;
  assign query_pos = query_pos_q;
  assign res_valid = res_valid_q;
  assign res_hit   = res_hit_q;
  assign res_t     = res_t_q;
`ifdef RAY_MARCH_STATS_EN
  assign res_steps = res_steps_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ray_march_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ray_march_ctrl
// Purpose  : Directed scoreboard bench for ray_march_ctrl with a behavioural
//            SDF (sphere r=0.1 at the origin, or a constant distance).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ray_march_ctrl;

  localparam int          L        = 2;
  localparam logic [31:0] MAX_DIST = 32'h0A000000;
  localparam logic [31:0] HIT_EPS  = 32'h00004189;
  localparam logic [31:0] RADIUS   = 32'h0019999A;
  localparam logic [31:0] ONE      = 32'h01000000;
  localparam logic [31:0] NEG_ONE  = 32'hFF000000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        ray_valid = 1'b0;
  logic        ray_ready;
  logic [95:0] ray_origin = '0;
  logic [95:0] ray_dir = '0;
  logic [95:0] query_pos;
  logic [31:0] query_dist = '0;
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic        res_hit;
  logic [31:0] res_t;
`ifdef RAY_MARCH_STATS_EN
  logic [7:0]  res_steps;
`endif

  ray_march_ctrl #(
    .SDF_LATENCY(L),
    .MAX_STEPS  (64),
    .HIT_EPS    (HIT_EPS),
    .MAX_DIST   (MAX_DIST)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ray_valid (ray_valid),
    .ray_ready (ray_ready),
    .ray_origin(ray_origin),
    .ray_dir   (ray_dir),
    .query_pos (query_pos),
    .query_dist(query_dist),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_hit   (res_hit),
    .res_t     (res_t)
`ifdef RAY_MARCH_STATS_EN
    ,
    .res_steps (res_steps)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  int accept_cyc = 0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Behavioural SDF: two-stage pipeline clocked on the falling edge.
  logic        sdf_mode = 1'b0;   // 0 = sphere, 1 = constant
  logic [31:0] sdf_const = '0;
  logic [31:0] sdf_s1 = '0;

  function automatic logic [31:0] sphere_sdf(input logic [95:0] p);
    real x, y, z, r;
    x = $itor($signed(p[31:0]))  / 16777216.0;
    y = $itor($signed(p[63:32])) / 16777216.0;
    z = $itor($signed(p[95:64])) / 16777216.0;
    r = $sqrt(x*x + y*y + z*z) - $itor(RADIUS) / 16777216.0;
    return 32'($rtoi(r * 16777216.0));
  endfunction

  always @(negedge clk) begin
    query_dist = sdf_s1;
    sdf_s1     = sdf_mode ? sdf_const : sphere_sdf(query_pos);
  end

  // Scoreboard.
  typedef struct {
    logic        hit;
    logic [31:0] t;
    logic        t_beyond;   // only require res_t > MAX_DIST
    logic [7:0]  steps;
  } exp_t;
  exp_t exp_q[$];

  task automatic expect_res(input logic hit, input logic [31:0] t, input logic t_beyond,
                            input logic [7:0] steps);
    exp_t e;
    e.hit = hit; e.t = t; e.t_beyond = t_beyond; e.steps = steps;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result: actual res_t=%h res_hit=%0d, required no result", res_t, res_hit);
      end else begin
        e = exp_q.pop_front();
        check("res_hit", 96'(res_hit), 96'(e.hit));
        if (e.t_beyond)
          check("res_t_beyond_max", 96'($signed(res_t) > $signed(MAX_DIST)), 96'(1));
        else
          check("res_t", 96'(res_t), 96'(e.t));
`ifdef RAY_MARCH_STATS_EN
        check("res_steps", 96'(res_steps), 96'(e.steps));
`endif
      end
    end
  end

  function automatic logic [95:0] vec(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return {z, y, x};
  endfunction

  task automatic send_ray(input logic [95:0] o, input logic [95:0] d);
    bit ok;
    ok = 0;
    @(posedge clk); #1;
    ray_origin = o;
    ray_dir    = d;
    ray_valid  = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ray_ready) begin
        ok = 1;
        accept_cyc = cyc;
        break;
      end
    end
    check("ray_accepted", 96'(ok), 96'(1));
    @(posedge clk); #1;
    ray_valid = 1'b0;
  endtask

  task automatic wait_results(input int budget);
    bit done;
    done = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        done = 1;
        break;
      end
    end
    check("results_drained", 96'(done), 96'(1));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ray_ready"}, 96'(ray_ready), 96'(0));
    check({tag, "_res_valid"}, 96'(res_valid), 96'(0));
    check({tag, "_res_hit"},   96'(res_hit),   96'(0));
    check({tag, "_res_t"},     96'(res_t),     96'(0));
    check({tag, "_query_pos"}, query_pos,      96'(0));
  endtask

  initial begin
    bit seen;
    int elapsed;

    // Reset state.
    #1 rst_n = 1'b0;
    #1 check_all_zero("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1 check("ready_before_first_edge", 96'(ray_ready), 96'(0));
    @(posedge clk); #1;
    check("ready_after_first_edge", 96'(ray_ready), 96'(1));

    // Sphere hit along +z, with result latency check.
    sdf_mode = 1'b0;
    expect_res(1'b1, 32'h00E66666, 1'b0, 8'd2);
    send_ray(vec(0, 0, NEG_ONE), vec(0, 0, ONE));
    seen = 0;
    elapsed = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (res_valid) begin
        seen = 1;
        elapsed = cyc - accept_cyc;
        break;
      end
    end
    check("hit_res_valid_seen", 96'(seen), 96'(1));
    check("hit_latency_cycles", 96'(elapsed), 96'(2 * (L + 2) + 2));
    wait_results(100);

    // Sphere miss along +y: five steps, last one jumps past MAX_DIST.
    expect_res(1'b0, '0, 1'b1, 8'd5);
    send_ray(vec(0, 0, NEG_ONE), vec(0, ONE, 0));
    wait_results(200);

    // Constant 0.01: step budget exhausted, t holds 63 accumulated steps.
    sdf_mode  = 1'b1;
    sdf_const = 32'h00028F5C;
    expect_res(1'b0, 32'(63 * 32'h00028F5C), 1'b0, 8'd64);
    send_ray(vec(0, 0, NEG_ONE), vec(0, 0, ONE));
    wait_results(1000);

    // Distance exactly HIT_EPS is not a hit.
    sdf_const = HIT_EPS;
    expect_res(1'b0, 32'(63 * HIT_EPS), 1'b0, 8'd64);
    send_ray(vec(0, 0, NEG_ONE), vec(0, 0, ONE));
    wait_results(1000);

    // Distance 5.0: t+d == MAX_DIST at step 2 is not a miss; step 3 is.
    sdf_const = 32'h05000000;
    expect_res(1'b0, 32'h0F000000, 1'b0, 8'd3);
    send_ray(vec(0, 0, NEG_ONE), vec(0, 0, ONE));
    wait_results(100);

    // Negative distance is a hit at step 1 with t = 0.
    sdf_const = 32'hFF800000;
    expect_res(1'b1, 32'h00000000, 1'b0, 8'd1);
    send_ray(vec(0, 0, NEG_ONE), vec(0, 0, ONE));
    wait_results(100);

    // Result back-pressure: outputs hold, no second ray accepted.
    sdf_mode  = 1'b0;
    res_ready = 1'b0;
    expect_res(1'b1, 32'h00E66666, 1'b0, 8'd2);
    send_ray(vec(0, 0, NEG_ONE), vec(0, 0, ONE));
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (res_valid) begin
        seen = 1;
        break;
      end
    end
    check("stall_res_valid_seen", 96'(seen), 96'(1));
    expect_res(1'b1, 32'h00E66666, 1'b0, 8'd2);
    ray_origin = vec(0, 0, NEG_ONE);
    ray_dir    = vec(0, 0, ONE);
    ray_valid  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_res_valid", 96'(res_valid), 96'(1));
      check("stall_res_hit",   96'(res_hit),   96'(1));
      check("stall_res_t",     96'(res_t),     96'(32'h00E66666));
      check("stall_ray_ready", 96'(ray_ready), 96'(0));
    end
    @(posedge clk); #1;
    res_ready = 1'b1;
    @(negedge clk);                 // handshake visible, taken on next edge
    @(negedge clk);
    check("post_handshake_ray_ready", 96'(ray_ready), 96'(1));
    check("post_handshake_res_valid", 96'(res_valid), 96'(0));
    @(posedge clk); #1;
    ray_valid = 1'b0;
    wait_results(100);

    // Reset during WAIT of step 3: ray discarded, outputs cleared.
    sdf_mode  = 1'b1;
    sdf_const = 32'h00028F5C;
    send_ray(vec(0, 0, NEG_ONE), vec(0, 0, ONE));
    repeat (2 * (L + 2) + 1) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check_all_zero("midflight_reset");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("in_reset_res_valid", 96'(res_valid), 96'(0));
    end
    rst_n = 1'b1;
    #1 check("release_ray_ready_low", 96'(ray_ready), 96'(0));
    @(posedge clk); #1;
    check("release_ray_ready_high", 96'(ray_ready), 96'(1));
    sdf_mode = 1'b0;
    expect_res(1'b1, 32'h00E66666, 1'b0, 8'd2);
    send_ray(vec(0, 0, NEG_ONE), vec(0, 0, ONE));
    wait_results(100);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 96'(exp_q.size()), 96'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
